// File: rtl/gp_elastic_slice.sv
// gp_elastic_slice: DEPTH-entry elastic register slice on a valid/ready stream.
// Circular buffer with explicit pointer wrap, occupancy count, almost-full
// watermark and a synchronous flush. rdy_m and vld_s/payld_s are driven from
// registered state (plus rst/flush gating), so there is no combinational path
// between the two sides of the slice.
//
// Handshake: a beat transfers on a side in any cycle where its valid and ready
// are both high at the rising edge. vld_s, once raised, stays up with a stable
// payld_s until it is accepted, unless rst or flush intervenes.
module gp_elastic_slice #(
    parameter int PAYLD_WIDTH = 32,
    parameter int DEPTH       = 2,
    parameter int AFULL_THR   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       vld_m,
    output logic                       rdy_m,
    input  logic [PAYLD_WIDTH-1:0]     payld_m,
    output logic                       vld_s,
    input  logic                       rdy_s,
    output logic [PAYLD_WIDTH-1:0]     payld_s,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AFULL_THR);

    logic [PAYLD_WIDTH-1:0] mem_q [DEPTH];
    logic [PAYLD_WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   push, pop;

    // Pointer advance with explicit wrap; DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Port-side signals: gated by rst/flush, otherwise purely from registered state.
    always_comb begin
        rdy_m       = ~rst & ~flush & (count_q != FULL_CNT);
        vld_s       = ~rst & ~flush & (count_q != '0);
        payld_s     = rst ? '0 : mem_q[rd_ptr_q];
        count       = rst ? '0 : count_q;
        almost_full = (count != '0) && (count >= AF_CNT);
        push        = vld_m & rdy_m;
        pop         = vld_s & rdy_s;
    end

    // Next-state: write on push only, so payld_m is ignored when no beat is accepted.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = payld_m;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // State registers; reset clears storage as well as pointers and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_gp_elastic_slice.sv
// Bench for gp_elastic_slice: instance a (DEPTH=4) and instance b (DEPTH=3),
// a queue-based reference model per instance checked every cycle, a
// vector table for fill/full behaviour, and hand-written corner sequences.
module tb_gp_elastic_slice;

    logic clk;
    logic rst;

    logic        a_flush, a_vld_m, a_rdy_m, a_vld_s, a_rdy_s, a_af;
    logic [31:0] a_payld_m, a_payld_s;
    logic [2:0]  a_count;

    logic        b_flush, b_vld_m, b_rdy_m, b_vld_s, b_rdy_s, b_af;
    logic [31:0] b_payld_m, b_payld_s;
    logic [1:0]  b_count;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    logic [31:0] a_exp_q[$];
    logic [31:0] b_exp_q[$];
    bit          a_after_rst = 0;
    bit          b_after_rst = 0;
    int          b_pops = 0;

    gp_elastic_slice #(.PAYLD_WIDTH(32), .DEPTH(4), .AFULL_THR(1)) a_dut (
        .clk(clk), .rst(rst), .flush(a_flush),
        .vld_m(a_vld_m), .rdy_m(a_rdy_m), .payld_m(a_payld_m),
        .vld_s(a_vld_s), .rdy_s(a_rdy_s), .payld_s(a_payld_s),
        .count(a_count), .almost_full(a_af)
    );

    gp_elastic_slice #(.PAYLD_WIDTH(32), .DEPTH(3), .AFULL_THR(1)) b_dut (
        .clk(clk), .rst(rst), .flush(b_flush),
        .vld_m(b_vld_m), .rdy_m(b_rdy_m), .payld_m(b_payld_m),
        .vld_s(b_vld_s), .rdy_s(b_rdy_s), .payld_s(b_payld_s),
        .count(b_count), .almost_full(b_af)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare one instance's outputs against the expectation derived from the model occupancy.
    task automatic check_side(input string p, input int depth, input int thr, input int sz,
                              input logic [31:0] head, input logic fl, input bit aft,
                              input logic act_rdy, input logic act_vld, input logic [31:0] act_pl,
                              input int act_cnt, input logic act_af);
        logic e_rdy, e_vld, e_af;
        int   e_cnt;
        e_rdy = !rst && !fl && (sz != depth);
        e_vld = !rst && !fl && (sz != 0);
        e_cnt = rst ? 0 : sz;
        e_af  = (e_cnt != 0) && (e_cnt >= depth - thr);
        chk({p, "_rdy_m"}, act_rdy, e_rdy);
        chk({p, "_vld_s"}, act_vld, e_vld);
        chk({p, "_count"}, act_cnt, e_cnt);
        chk({p, "_almost_full"}, act_af, e_af);
        if (e_vld) chk({p, "_payld_s"}, act_pl, head);
        if (rst || aft) chk({p, "_payld_s_rst"}, act_pl, 32'h0);
    endtask

    // Reference model: FIFO occupancy and contents updated at each edge.
    always @(posedge clk) begin
        if (rst) begin
            a_exp_q.delete();
            b_exp_q.delete();
            a_after_rst = 1;
            b_after_rst = 1;
        end else begin
            a_after_rst = 0;
            b_after_rst = 0;
            if (a_flush) a_exp_q.delete();
            else begin
                bit pu, po;
                pu = a_vld_m && (a_exp_q.size() < 4);
                po = a_rdy_s && (a_exp_q.size() > 0);
                if (po) void'(a_exp_q.pop_front());
                if (pu) a_exp_q.push_back(a_payld_m);
            end
            if (b_flush) b_exp_q.delete();
            else begin
                bit pu, po;
                pu = b_vld_m && (b_exp_q.size() < 3);
                po = b_rdy_s && (b_exp_q.size() > 0);
                if (po) begin
                    void'(b_exp_q.pop_front());
                    b_pops++;
                end
                if (pu) b_exp_q.push_back(b_payld_m);
            end
        end
    end

    // Scoreboard compare away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check_side("a", 4, 1, a_exp_q.size(), (a_exp_q.size() != 0) ? a_exp_q[0] : 32'h0,
                       a_flush, a_after_rst, a_rdy_m, a_vld_s, a_payld_s, int'(a_count), a_af);
            check_side("b", 3, 1, b_exp_q.size(), (b_exp_q.size() != 0) ? b_exp_q[0] : 32'h0,
                       b_flush, b_after_rst, b_rdy_m, b_vld_s, b_payld_s, int'(b_count), b_af);
            chk("b_wr_ptr_range", 32'(b_dut.wr_ptr_q < 2'd3), 32'h1);
            chk("b_rd_ptr_range", 32'(b_dut.rd_ptr_q < 2'd3), 32'h1);
        end
    end

    typedef struct {
        logic        vld;
        logic [31:0] payld;
        logic        rdy_s;
        logic        e_vld;
        logic [31:0] e_payld;
        logic [2:0]  e_cnt;
        logic        e_rdy;
        logic        e_af;
    } vec_t;

    function automatic vec_t mkv(input logic vld, input logic [31:0] payld, input logic rdy_s,
                                 input logic e_vld, input logic [31:0] e_payld,
                                 input logic [2:0] e_cnt, input logic e_rdy, input logic e_af);
        vec_t v;
        v.vld = vld; v.payld = payld; v.rdy_s = rdy_s;
        v.e_vld = e_vld; v.e_payld = e_payld; v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_af = e_af;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[13];

    initial begin
        // Fill/full table on instance a (DEPTH=4, almost_full at count>=3).
        tbl[0]  = mkv(1, 32'hA0, 0,  0, 32'h00, 3'd0, 1, 0);
        tbl[1]  = mkv(1, 32'hA1, 0,  1, 32'hA0, 3'd1, 1, 0);
        tbl[2]  = mkv(1, 32'hA2, 0,  1, 32'hA0, 3'd2, 1, 0);
        tbl[3]  = mkv(1, 32'hA3, 0,  1, 32'hA0, 3'd3, 1, 1);
        tbl[4]  = mkv(1, 32'hA4, 0,  1, 32'hA0, 3'd4, 0, 1);
        tbl[5]  = mkv(1, 32'hA4, 1,  1, 32'hA0, 3'd4, 0, 1);
        tbl[6]  = mkv(1, 32'hA4, 0,  1, 32'hA1, 3'd3, 1, 1);
        tbl[7]  = mkv(1, 32'hA5, 1,  1, 32'hA1, 3'd4, 0, 1);
        tbl[8]  = mkv(1, 32'hA5, 1,  1, 32'hA2, 3'd3, 1, 1);
        tbl[9]  = mkv(0, 32'h00, 1,  1, 32'hA3, 3'd3, 1, 1);
        tbl[10] = mkv(0, 32'h00, 1,  1, 32'hA4, 3'd2, 1, 0);
        tbl[11] = mkv(0, 32'h00, 1,  1, 32'hA5, 3'd1, 1, 0);
        tbl[12] = mkv(0, 32'h00, 0,  0, 32'h00, 3'd0, 1, 0);

        // Reset held 3 cycles with vld_m high on both instances.
        rst = 1'b1;
        a_flush = 0; a_vld_m = 1; a_payld_m = 32'h55; a_rdy_s = 0;
        b_flush = 0; b_vld_m = 1; b_payld_m = 32'h66; b_rdy_s = 0;
        chk_en = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_a_rdy_m", a_rdy_m, 1'b0);
            chk("rst_a_vld_s", a_vld_s, 1'b0);
            chk("rst_a_count", a_count, 3'd0);
            chk("rst_a_payld_s", a_payld_s, 32'h0);
            chk("rst_b_rdy_m", b_rdy_m, 1'b0);
        end
        step();
        rst = 0; a_vld_m = 0; b_vld_m = 0;
        @(negedge clk);
        chk("post_rst_a_rdy_m", a_rdy_m, 1'b1);
        chk("post_rst_a_vld_s", a_vld_s, 1'b0);
        chk("post_rst_a_payld_s", a_payld_s, 32'h0);
        chk("post_rst_b_rdy_m", b_rdy_m, 1'b1);

        // Streaming 0x1..0x10 with rdy_s=1: one-cycle latency, count stays 1.
        for (int k = 0; k <= 16; k++) begin
            step();
            a_rdy_s   = 1;
            a_vld_m   = (k < 16);
            a_payld_m = (k < 16) ? 32'(k + 1) : 32'h0;
            @(negedge clk);
            if (k == 0) begin
                chk("stream_first_vld_s", a_vld_s, 1'b0);
            end else begin
                chk("stream_vld_s", a_vld_s, 1'b1);
                chk("stream_payld_s", a_payld_s, 32'(k));
                chk("stream_count", a_count, 3'd1);
                chk("stream_rdy_m", a_rdy_m, 1'b1);
            end
        end

        // Fill, full, full-with-pop and drain from the vector table.
        for (int i = 0; i < 13; i++) begin
            step();
            a_vld_m = tbl[i].vld; a_payld_m = tbl[i].payld; a_rdy_s = tbl[i].rdy_s;
            @(negedge clk);
            chk($sformatf("tbl%0d_vld_s", i), a_vld_s, tbl[i].e_vld);
            chk($sformatf("tbl%0d_count", i), a_count, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_rdy_m", i), a_rdy_m, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_af", i), a_af, tbl[i].e_af);
            if (tbl[i].e_vld) chk($sformatf("tbl%0d_payld_s", i), a_payld_s, tbl[i].e_payld);
        end

        // Flush at count=3 with vld_m and rdy_s both high.
        for (int i = 0; i < 3; i++) begin
            step();
            a_vld_m = 1; a_payld_m = 32'hC0 + 32'(i); a_rdy_s = 0;
        end
        step();
        a_flush = 1; a_vld_m = 1; a_payld_m = 32'hDD; a_rdy_s = 1;
        @(negedge clk);
        chk("flush_rdy_m", a_rdy_m, 1'b0);
        chk("flush_vld_s", a_vld_s, 1'b0);
        step();
        a_flush = 0; a_vld_m = 1; a_payld_m = 32'hB0; a_rdy_s = 0;
        @(negedge clk);
        chk("post_flush_count", a_count, 3'd0);
        chk("post_flush_vld_s", a_vld_s, 1'b0);
        chk("post_flush_rdy_m", a_rdy_m, 1'b1);
        step();
        a_vld_m = 0; a_payld_m = 32'h0;
        @(negedge clk);
        chk("flush_b0_vld_s", a_vld_s, 1'b1);
        chk("flush_b0_payld_s", a_payld_s, 32'hB0);
        chk("flush_b0_count", a_count, 3'd1);
        step();
        a_rdy_s = 1;
        step();
        a_rdy_s = 0;

        // Random traffic on instance b (DEPTH=3) with rare flushes and one reset.
        begin
            int cyc = 0;
            while (b_pops < 2000 && cyc < 20000) begin
                step();
                b_vld_m   = 1'($urandom_range(0, 1));
                b_payld_m = $urandom;
                b_rdy_s   = 1'($urandom_range(0, 1));
                b_flush   = ($urandom_range(0, 199) == 0);
                rst       = (cyc >= 1000 && cyc < 1002);
                cyc++;
            end
            chk("b_beat_budget", 32'(b_pops >= 2000), 32'h1);
        end
        step();
        rst = 0; b_flush = 0; b_vld_m = 0; b_rdy_s = 1;
        repeat (5) step();
        @(negedge clk);
        chk("b_drained_vld_s", b_vld_s, 1'b0);
        chk_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
